// File: rtl/microblaze_0_bram_port_arbiter.sv
// Two-requester round-robin arbiter with a per-owner burst cap. It time-shares
// port B of the MicroBlaze local-memory BRAM and returns read data with a
// fixed 3-cycle latency, tagged to the requester that issued the access.
module microblaze_0_bram_port_arbiter #(
  parameter logic [31:0] C_BASEADDR    = 32'h0000_0000,
  parameter logic [31:0] C_MEMSIZE     = 32'h0000_4000,
  parameter int unsigned C_PORT_DWIDTH = 32,
  parameter int unsigned C_PORT_AWIDTH = 32,
  parameter int unsigned C_NUM_WE      = 4,
  parameter int unsigned C_MAX_BURST   = 4
) (
  input  logic                     BRAM_Clk,
  input  logic                     BRAM_Rst,
  input  logic                     M0_Req,
  input  logic                     M0_Wr,
  input  logic [0:C_PORT_AWIDTH-1] M0_Addr,
  input  logic [0:C_PORT_DWIDTH-1] M0_WData,
  input  logic [0:C_NUM_WE-1]      M0_BE,
  output logic                     M0_Gnt,
  output logic                     M0_RdValid,
  output logic [0:C_PORT_DWIDTH-1] M0_RData,
  output logic                     M0_Err,
  input  logic                     M1_Req,
  input  logic                     M1_Wr,
  input  logic [0:C_PORT_AWIDTH-1] M1_Addr,
  input  logic [0:C_PORT_DWIDTH-1] M1_WData,
  input  logic [0:C_NUM_WE-1]      M1_BE,
  output logic                     M1_Gnt,
  output logic                     M1_RdValid,
  output logic [0:C_PORT_DWIDTH-1] M1_RData,
  output logic                     M1_Err,
  output logic                     BRAM_EN,
  output logic [0:C_NUM_WE-1]      BRAM_WEN,
  output logic [0:C_PORT_AWIDTH-1] BRAM_Addr,
  output logic [0:C_PORT_DWIDTH-1] BRAM_Dout,
  input  logic [0:C_PORT_DWIDTH-1] BRAM_Din
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] MAX_BURST = CNT_W'(C_MAX_BURST);
  localparam logic [C_PORT_AWIDTH-1:0] BASE_ADDR = C_PORT_AWIDTH'(C_BASEADDR);
  localparam logic [C_PORT_AWIDTH-1:0] MEM_SIZE  = C_PORT_AWIDTH'(C_MEMSIZE);
  localparam logic [C_PORT_AWIDTH-1:0] WORD_MASK = ~C_PORT_AWIDTH'(3);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_e;

  arb_state_e       state, state_nxt;
  logic [CNT_W-1:0] burst_cnt, burst_cnt_nxt;
  logic             gnt0_c, gnt1_c;
  logic             accept_c;

  logic                     sel_wr;
  logic [C_PORT_AWIDTH-1:0] sel_addr;
  logic [C_PORT_DWIDTH-1:0] sel_wdata;
  logic [C_NUM_WE-1:0]      sel_be;
  logic [C_PORT_AWIDTH-1:0] offset;
  logic                     in_win;

  logic                     en_q;
  logic [C_NUM_WE-1:0]      wen_q;
  logic [C_PORT_AWIDTH-1:0] addr_q;
  logic [C_PORT_DWIDTH-1:0] dout_q;

  logic s1_valid, s1_id, s1_rd, s1_err;
  logic s2_valid, s2_id, s2_rd, s2_err;

  logic                     rd_valid0_q, rd_valid1_q, err0_q, err1_q;
  logic [C_PORT_DWIDTH-1:0] rdata0_q, rdata1_q;

  // Arbiter state and burst counter register
  always_ff @(posedge BRAM_Clk) begin
    if (BRAM_Rst) begin
      state     <= ST_IDLE;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      burst_cnt <= burst_cnt_nxt;
    end
  end

  // Grant decision and next arbiter state; grants depend only on Req, state and burst_cnt
  always_comb begin
    gnt0_c        = 1'b0;
    gnt1_c        = 1'b0;
    state_nxt     = state;
    burst_cnt_nxt = burst_cnt;
    if (!BRAM_Rst) begin
      if (M0_Req && !M1_Req) begin
        gnt0_c = 1'b1;
      end else if (M1_Req && !M0_Req) begin
        gnt1_c = 1'b1;
      end else if (M0_Req && M1_Req) begin
        unique case (state)
          ST_OWN0: begin
            if (burst_cnt < MAX_BURST) gnt0_c = 1'b1;
            else                       gnt1_c = 1'b1;
          end
          ST_OWN1: begin
            if (burst_cnt < MAX_BURST) gnt1_c = 1'b1;
            else                       gnt0_c = 1'b1;
          end
          default: gnt0_c = 1'b1;
        endcase
      end

      if (gnt0_c) begin
        state_nxt = ST_OWN0;
        if (state == ST_OWN0)
          burst_cnt_nxt = (burst_cnt < MAX_BURST) ? burst_cnt + CNT_W'(1) : burst_cnt;
        else
          burst_cnt_nxt = CNT_W'(1);
      end else if (gnt1_c) begin
        state_nxt = ST_OWN1;
        if (state == ST_OWN1)
          burst_cnt_nxt = (burst_cnt < MAX_BURST) ? burst_cnt + CNT_W'(1) : burst_cnt;
        else
          burst_cnt_nxt = CNT_W'(1);
      end else begin
        state_nxt     = ST_IDLE;
        burst_cnt_nxt = '0;
      end
    end
  end

  assign M0_Gnt   = gnt0_c;
  assign M1_Gnt   = gnt1_c;
  assign accept_c = gnt0_c | gnt1_c;

  // Select the granted requester's access and range-check it against the window
  always_comb begin
    sel_wr    = gnt1_c ? M1_Wr    : M0_Wr;
    sel_addr  = gnt1_c ? M1_Addr  : M0_Addr;
    sel_wdata = gnt1_c ? M1_WData : M0_WData;
    sel_be    = gnt1_c ? M1_BE    : M0_BE;
    offset    = sel_addr - BASE_ADDR;
    in_win    = (offset < MEM_SIZE);
  end

  // Registered BRAM port drive; out-of-window accesses never enable the BRAM
  always_ff @(posedge BRAM_Clk) begin
    if (BRAM_Rst) begin
      en_q   <= 1'b0;
      wen_q  <= '0;
      addr_q <= '0;
      dout_q <= '0;
    end else begin
      en_q  <= accept_c && in_win;
      wen_q <= (accept_c && in_win && sel_wr) ? sel_be : '0;
      if (accept_c && in_win) begin
        addr_q <= offset & WORD_MASK;
        dout_q <= sel_wdata;
      end
    end
  end

  // Reset also squashes whatever access is already on the port this cycle
  assign BRAM_EN   = en_q & ~BRAM_Rst;
  assign BRAM_WEN  = BRAM_Rst ? '0 : wen_q;
  assign BRAM_Addr = addr_q;
  assign BRAM_Dout = dout_q;

  // Requester tag pipeline aligned with the BRAM read latency
  always_ff @(posedge BRAM_Clk) begin
    if (BRAM_Rst) begin
      s1_valid <= 1'b0;
      s1_id    <= 1'b0;
      s1_rd    <= 1'b0;
      s1_err   <= 1'b0;
      s2_valid <= 1'b0;
      s2_id    <= 1'b0;
      s2_rd    <= 1'b0;
      s2_err   <= 1'b0;
    end else begin
      s1_valid <= accept_c;
      s1_id    <= gnt1_c;
      s1_rd    <= ~sel_wr;
      s1_err   <= ~in_win;
      s2_valid <= s1_valid;
      s2_id    <= s1_id;
      s2_rd    <= s1_rd;
      s2_err   <= s1_err;
    end
  end

  // Response stage: route read data and error pulses to the issuing requester
  always_ff @(posedge BRAM_Clk) begin
    if (BRAM_Rst) begin
      rd_valid0_q <= 1'b0;
      rd_valid1_q <= 1'b0;
      err0_q      <= 1'b0;
      err1_q      <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      rd_valid0_q <= s2_valid && !s2_id && s2_rd;
      rd_valid1_q <= s2_valid &&  s2_id && s2_rd;
      err0_q      <= s2_valid && !s2_id && s2_err;
      err1_q      <= s2_valid &&  s2_id && s2_err;
      if (s2_valid && !s2_id && s2_rd)
        rdata0_q <= s2_err ? '0 : BRAM_Din;
      if (s2_valid && s2_id && s2_rd)
        rdata1_q <= s2_err ? '0 : BRAM_Din;
    end
  end

  assign M0_RdValid = rd_valid0_q;
  assign M1_RdValid = rd_valid1_q;
  assign M0_Err     = err0_q;
  assign M1_Err     = err1_q;
  assign M0_RData   = rdata0_q;
  assign M1_RData   = rdata1_q;

endmodule
